// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master controller: frame geometry, FSM states
// and the registered response bundle.
package spi_pkg;

    localparam int FRAME_BITS = 16;
    localparam int ADDR_BITS  = 7;
    localparam int DATA_BITS  = 8;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        GAP,
        ERR
    } spi_state_e;

    typedef struct packed {
        logic [DATA_BITS-1:0] rdata;
        logic                 err;
    } spi_rsp_t;

endpackage

// File: rtl/spi_clk_gen.sv
// SCLK divider: toggles the registered SCLK every CLK_DIV cycles while enabled
// and flags whether the edge being produced is the leading or trailing one.
module spi_clk_gen #(
    parameter logic CPOL    = 1'b0,
    parameter int   CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    output logic o_sclk,
    output logic o_lead_stb,
    output logic o_trail_stb
);

    localparam int             CW       = $clog2(CLK_DIV + 1);
    localparam logic [CW-1:0]  DIV_LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] r_div_cnt;
    logic          r_sclk;
    logic          w_stb;

    // Strobes fire on the clk edge that moves SCLK, so the controller can act in lockstep.
    assign w_stb       = i_en && (r_div_cnt == DIV_LAST);
    assign o_lead_stb  = w_stb && (r_sclk == CPOL);
    assign o_trail_stb = w_stb && (r_sclk != CPOL);
    assign o_sclk      = r_sclk;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div_cnt <= '0;
            r_sclk    <= CPOL;
        end else if (!i_en) begin
            r_div_cnt <= '0;
            r_sclk    <= CPOL;
        end else if (w_stb) begin
            r_div_cnt <= '0;
            r_sclk    <= ~r_sclk;
        end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI master sequencer: turns one accepted command into a single 16-bit frame
// (command byte then data byte) and reports completion on a one-cycle response.
module spi_master_ctrl
    import spi_pkg::*;
#(
    parameter logic CPOL    = 1'b0,
    parameter logic CPHA    = 1'b0,
    parameter int   SLAVES  = 1,
    parameter int   CLK_DIV = 4,
    parameter int   SID_W   = $clog2(SLAVES) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_write,
    input  logic [SID_W-1:0]     cmd_slave,
    input  logic [ADDR_BITS-1:0] cmd_addr,
    input  logic [DATA_BITS-1:0] cmd_wdata,
    output logic                 rsp_valid,
    output logic [DATA_BITS-1:0] rsp_rdata,
    output logic                 rsp_err,
    output logic                 busy,
    output logic                 SCLK,
    output logic [SLAVES-1:0]    SS,
    output logic                 MOSI,
    input  logic                 MISO
);

    localparam int               CW        = $clog2(CLK_DIV + 1);
    localparam logic [CW-1:0]    DIV_LAST  = CW'(CLK_DIV - 1);
    localparam logic [SID_W-1:0] SLV_LIM   = SID_W'(SLAVES);
    localparam logic [5:0]       LAST_EDGE = 6'(2 * FRAME_BITS - 1);

    spi_state_e            r_state;
    logic [SLAVES-1:0]     r_ss;
    logic                  r_mosi;
    logic                  r_rsp_valid;
    logic                  r_write;
    spi_rsp_t              r_rsp;
    logic [FRAME_BITS-1:0] r_tx;
    logic [DATA_BITS-1:0]  r_rx;
    logic [CW-1:0]         r_cnt;
    logic [5:0]            r_edge_cnt;

    logic [FRAME_BITS-1:0] w_frame;
    logic                  w_shift_en;
    logic                  w_sclk;
    logic                  w_lead_stb;
    logic                  w_trail_stb;
    logic                  w_sample_stb;
    logic                  w_shift_stb;
    logic                  w_last_edge;
    logic                  w_cnt_done;

    // Reads send zeros in the data byte so the slave never sees stale write data.
    assign w_frame      = {cmd_write, cmd_addr, cmd_write ? cmd_wdata : {DATA_BITS{1'b0}}};
    assign w_shift_en   = (r_state == SHIFT);
    assign w_sample_stb = CPHA ? w_trail_stb : w_lead_stb;
    assign w_shift_stb  = CPHA ? w_lead_stb : w_trail_stb;
    assign w_last_edge  = (r_edge_cnt == LAST_EDGE);
    assign w_cnt_done   = (r_cnt == DIV_LAST);

    spi_clk_gen #(
        .CPOL    (CPOL),
        .CLK_DIV (CLK_DIV)
    ) u_clk_gen (
        .clk         (clk),
        .rst         (rst),
        .i_en        (w_shift_en),
        .o_sclk      (w_sclk),
        .o_lead_stb  (w_lead_stb),
        .o_trail_stb (w_trail_stb)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_ss        <= '1;
            r_mosi      <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_write     <= 1'b0;
            r_rsp       <= '0;
            r_tx        <= '0;
            r_rx        <= '0;
            r_cnt       <= '0;
            r_edge_cnt  <= '0;
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (cmd_valid) begin
                        r_write    <= cmd_write;
                        r_cnt      <= '0;
                        r_edge_cnt <= '0;
                        if (cmd_slave >= SLV_LIM) begin
                            r_state     <= ERR;
                            r_rsp_valid <= 1'b1;
                            r_rsp       <= '{rdata: '0, err: 1'b1};
                        end else begin
                            r_state <= SETUP;
                            for (int i = 0; i < SLAVES; i++) begin
                                r_ss[i] <= (SID_W'(i) != cmd_slave);
                            end
                            // With CPHA=0 the first bit must be on the wire before the first sampling edge.
                            if (!CPHA) begin
                                r_mosi <= w_frame[FRAME_BITS-1];
                                r_tx   <= {w_frame[FRAME_BITS-2:0], 1'b0};
                            end else begin
                                r_mosi <= 1'b0;
                                r_tx   <= w_frame;
                            end
                        end
                    end
                end
                ERR: begin
                    r_state <= IDLE;
                end
                SETUP: begin
                    if (w_cnt_done) begin
                        r_state <= SHIFT;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                SHIFT: begin
                    if (w_sample_stb) begin
                        r_rx <= {r_rx[DATA_BITS-2:0], MISO};
                    end
                    if (w_shift_stb && !(!CPHA && w_last_edge)) begin
                        r_mosi <= r_tx[FRAME_BITS-1];
                        r_tx   <= {r_tx[FRAME_BITS-2:0], 1'b0};
                    end
                    if (w_lead_stb || w_trail_stb) begin
                        if (w_last_edge) begin
                            r_state    <= HOLD;
                            r_edge_cnt <= '0;
                            r_cnt      <= '0;
                        end else begin
                            r_edge_cnt <= r_edge_cnt + 6'd1;
                        end
                    end
                end
                HOLD: begin
                    if (w_cnt_done) begin
                        r_state     <= GAP;
                        r_cnt       <= '0;
                        r_ss        <= '1;
                        r_mosi      <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp.rdata <= r_write ? '0 : r_rx;
                        r_rsp.err   <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                GAP: begin
                    if (w_cnt_done) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign cmd_ready = (r_state == IDLE);
    assign busy      = (r_state != IDLE);
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp.rdata;
    assign rsp_err   = r_rsp.err;
    assign SCLK      = w_sclk;
    assign SS        = r_ss;
    assign MOSI      = r_mosi;

endmodule
